// File: rtl/priority_irq_encoder.sv
// Registered priority encoder for interrupt-style request lines.
// Captures request edges (or levels) into a pending register and presents the highest eligible index.
module priority_irq_encoder #(
  parameter int unsigned N      = 8,
  parameter int unsigned IDX_W  = 3,
  parameter int unsigned STICKY = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     req,
  input  logic [N-1:0]     mask,
  output logic             out_valid,
  output logic [IDX_W-1:0] out_idx,
  input  logic             out_ready,
  output logic [N-1:0]     pending,
  output logic             any_pending
);

  typedef enum logic {
    IDLE,
    PRESENT
  } state_t;

  state_t             state;
  logic [N-1:0]       req_q;
  logic [N-1:0]       pend;
  logic [N-1:0]       rise;
  logic [N-1:0]       eligible;
  logic [N-1:0]       clr;
  logic [IDX_W-1:0]   win_idx;
  logic               win_any;
  logic               hs;

  assign hs          = out_valid & out_ready;
  assign rise        = req & ~req_q;
  assign eligible    = pend & mask;
  assign pending     = pend;
  assign any_pending = |pend;

  // Ascending scan so the last (highest) set index overrides lower ones.
  always_comb begin
    win_idx = '0;
    win_any = |eligible;
    for (int unsigned i = 0; i < N; i++) begin
      if (eligible[i]) win_idx = IDX_W'(i);
    end
  end

  always_comb begin
    clr = '0;
    for (int unsigned i = 0; i < N; i++) begin
      clr[i] = hs && (out_idx == IDX_W'(i));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      req_q     <= req;
      pend      <= '0;
      out_valid <= 1'b0;
      out_idx   <= '0;
      state     <= IDLE;
    end else begin
      req_q <= req;
      // A new edge on the bit being acknowledged wins over its clear.
      if (STICKY != 0) pend <= (pend & ~clr) | rise;
      else             pend <= req;

      case (state)
        IDLE: begin
          if (win_any) begin
            out_idx   <= win_idx;
            out_valid <= 1'b1;
            state     <= PRESENT;
          end
        end
        PRESENT: begin
          if (hs) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_priority_irq_encoder.sv
// Directed self-checking bench for priority_irq_encoder (sticky N=8 and level N=12 instances).
module tb_priority_irq_encoder;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  req, mask;
  logic        out_ready;
  logic        out_valid;
  logic [2:0]  out_idx;
  logic [7:0]  pending;
  logic        any_pending;

  logic [11:0] req2, mask2;
  logic        out_ready2;
  logic        out_valid2;
  logic [3:0]  out_idx2;
  logic [11:0] pending2;
  logic        any_pending2;

  int unsigned errors = 0;
  int unsigned checks = 0;

  always #5 clk = ~clk;

  priority_irq_encoder #(.N(8), .IDX_W(3), .STICKY(1)) dut (
    .clk(clk), .rst(rst), .req(req), .mask(mask),
    .out_valid(out_valid), .out_idx(out_idx), .out_ready(out_ready),
    .pending(pending), .any_pending(any_pending)
  );

  priority_irq_encoder #(.N(12), .IDX_W(4), .STICKY(0)) dut_lvl (
    .clk(clk), .rst(rst), .req(req2), .mask(mask2),
    .out_valid(out_valid2), .out_idx(out_idx2), .out_ready(out_ready2),
    .pending(pending2), .any_pending(any_pending2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock edge; outputs are sampled 1 ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; req = 8'hFF; mask = 8'hFF; out_ready = 1'b1;
    req2 = '0; mask2 = 12'hFFF; out_ready2 = 1'b1;
    tick(); tick();
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_idx", 32'(out_idx), 32'd0);
    check("rst_pending", 32'(pending), 32'h0);
    check("rst_any", 32'(any_pending), 32'd0);
    check("rst_lvl_valid", 32'(out_valid2), 32'd0);

    // 1: level held through reset never produces an edge
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("held_valid", 32'(out_valid), 32'd0);
      check("held_pending", 32'(pending), 32'h0);
    end
    req = 8'h00;
    tick();

    // 2: simultaneous edges on 2 and 5
    req = 8'h24;
    tick();
    req = 8'h00;
    check("t2_pend", 32'(pending), 32'h24);
    check("t2_nvalid", 32'(out_valid), 32'd0);
    tick();
    check("t2_valid5", 32'(out_valid), 32'd1);
    check("t2_idx5", 32'(out_idx), 32'd5);
    tick();
    check("t2_ack5_valid", 32'(out_valid), 32'd0);
    check("t2_ack5_pend", 32'(pending), 32'h04);
    tick();
    check("t2_valid2", 32'(out_valid), 32'd1);
    check("t2_idx2", 32'(out_idx), 32'd2);
    tick();
    check("t2_any", 32'(any_pending), 32'd0);
    check("t2_end_valid", 32'(out_valid), 32'd0);

    // 3: masked line pends but is not presented
    mask = 8'h7F;
    req = 8'h82;
    tick();
    req = 8'h00;
    tick();
    check("t3_idx1", 32'(out_idx), 32'd1);
    check("t3_valid1", 32'(out_valid), 32'd1);
    tick();
    check("t3_pend80", 32'(pending), 32'h80);
    for (int i = 0; i < 3; i++) begin
      check("t3_masked_nvalid", 32'(out_valid), 32'd0);
      tick();
    end
    check("t3_masked_any", 32'(any_pending), 32'd1);
    mask = 8'hFF;
    tick();
    check("t3_valid7", 32'(out_valid), 32'd1);
    check("t3_idx7", 32'(out_idx), 32'd7);
    tick();
    check("t3_clear", 32'(pending), 32'h0);

    // 4: stalled presentation is not replaced by a higher arrival
    out_ready = 1'b0;
    req = 8'h08;
    tick();
    req = 8'h00;
    tick();
    for (int i = 0; i < 5; i++) begin
      req = (i == 1) ? 8'h40 : 8'h00;
      check("t4_stall_valid", 32'(out_valid), 32'd1);
      check("t4_stall_idx", 32'(out_idx), 32'd3);
      tick();
    end
    req = 8'h00;
    check("t4_pend48", 32'(pending), 32'h48);
    out_ready = 1'b1;
    tick();
    check("t4_ack3_valid", 32'(out_valid), 32'd0);
    check("t4_ack3_pend", 32'(pending), 32'h40);
    tick();
    check("t4_valid6", 32'(out_valid), 32'd1);
    check("t4_idx6", 32'(out_idx), 32'd6);
    tick();
    check("t4_clear", 32'(pending), 32'h0);

    // 5: new edge on the bit being acknowledged is kept
    req = 8'h10;
    tick();
    req = 8'h00;
    tick();
    check("t5_idx4", 32'(out_idx), 32'd4);
    check("t5_valid4", 32'(out_valid), 32'd1);
    req = 8'h10;
    tick();
    req = 8'h00;
    check("t5_kept", 32'(pending), 32'h10);
    check("t5_ack_valid", 32'(out_valid), 32'd0);
    tick();
    check("t5_re_valid", 32'(out_valid), 32'd1);
    check("t5_re_idx", 32'(out_idx), 32'd4);
    tick();
    check("t5_any", 32'(any_pending), 32'd0);

    // 6: level mode, N=12
    req2 = 12'h801;
    tick();
    check("t6_pend", 32'(pending2), 32'h801);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t6_valid11", 32'(out_valid2), 32'd1);
      check("t6_idx11", 32'(out_idx2), 32'd11);
      tick();
      check("t6_ack_valid", 32'(out_valid2), 32'd0);
      check("t6_ack_pend", 32'(pending2), 32'h801);
    end
    tick();
    check("t6_last11", 32'(out_idx2), 32'd11);
    req2 = 12'h001;
    tick();
    check("t6_drop_pend", 32'(pending2), 32'h001);
    check("t6_drop_valid", 32'(out_valid2), 32'd0);
    tick();
    check("t6_valid0", 32'(out_valid2), 32'd1);
    check("t6_idx0", 32'(out_idx2), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
